swap_sched: RTL and testbench

- Shared pair-swap engine with a round-robin front end.
- Up to NREQ requesters each present an operand pair (a, b) and a swap count.
- The block grants one requester at a time, loads the pair into its internal two-register swap datapath, and executes one a<->b exchange per clock for the requested count.
- It then returns the resulting pair with a one-cycle acknowledge to the granted requester.

---
 rtl/swap_sched.sv | 156 +++++++++++++++
 tb/tb_swap_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/swap_sched.sv
// swap_sched: round-robin front end feeding a shared two-register swap engine.
// One requester is granted at a time; its pair is exchanged once per clock for
// the requested count and the final pair is returned with a one-cycle ack.
module swap_sched #(
   parameter  int NREQ = 4,
   parameter  int W    = 8,
   parameter  int CW   = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_i,
   input  logic [NREQ*W-1:0] a_i,
   input  logic [NREQ*W-1:0] b_i,
   input  logic [NREQ*CW-1:0] cnt_i,
   output logic [NREQ-1:0]   ack_o,
   output logic              done_o,
   output logic [IDW-1:0]    gnt_id_o,
   output logic [W-1:0]      a_o,
   output logic [W-1:0]      b_o,
   output logic              busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SWAP = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_d;
   logic [IDW-1:0]  rr_ptr, rr_ptr_d;
   logic [W-1:0]    pair_a, pair_a_d;
   logic [W-1:0]    pair_b, pair_b_d;
   logic [CW-1:0]   rem, rem_d;
   logic [IDW-1:0]  gnt_d;
   logic [W-1:0]    a_d, b_d;
   logic [NREQ-1:0] ack_d;
   logic            done_d, busy_d;

   logic            sel_vld;
   logic [IDW-1:0]  sel_id;
   logic [W-1:0]    sel_a, sel_b;
   logic [CW-1:0]   sel_cnt;

   // Round-robin pick: first pending request at or above rr_ptr, wrapping.
   // The scan runs from the farthest offset down so the nearest one wins.
   always_comb begin
      int idx;
      idx     = 0;
      sel_vld = 1'b0;
      sel_id  = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = (int'(rr_ptr) + i) % NREQ;
         if (req_i[idx]) begin
            sel_vld = 1'b1;
            sel_id  = IDW'(idx);
         end
      end
   end

   assign sel_a   = a_i[sel_id*W +: W];
   assign sel_b   = b_i[sel_id*W +: W];
   assign sel_cnt = cnt_i[sel_id*CW +: CW];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   // Next-state logic: SWAP is skipped entirely for a zero count.
   always_comb begin
      state_d = state;
      case (state)
         IDLE: if (sel_vld) state_d = (sel_cnt != '0) ? SWAP : DONE;
         SWAP: if (rem == CW'(1)) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values for datapath and output registers. Outputs are registered,
   // so the DONE-cycle values are loaded on the edge that enters DONE.
   always_comb begin
      pair_a_d = pair_a;
      pair_b_d = pair_b;
      rem_d    = rem;
      rr_ptr_d = rr_ptr;
      gnt_d    = gnt_id_o;
      a_d      = a_o;
      b_d      = b_o;
      ack_d    = '0;
      done_d   = 1'b0;
      busy_d   = (state_d != IDLE);
      case (state)
         IDLE: begin
            if (sel_vld) begin
               pair_a_d = sel_a;
               pair_b_d = sel_b;
               rem_d    = sel_cnt;
               gnt_d    = sel_id;
               if (sel_cnt == '0) begin
                  a_d    = sel_a;
                  b_d    = sel_b;
                  done_d = 1'b1;
                  ack_d  = NREQ'(1) << sel_id;
               end
            end
         end
         SWAP: begin
            // rem is at least 1 here, so the decrement cannot wrap.
            pair_a_d = pair_b;
            pair_b_d = pair_a;
            rem_d    = rem - CW'(1);
            if (rem == CW'(1)) begin
               a_d    = pair_b;
               b_d    = pair_a;
               done_d = 1'b1;
               ack_d  = NREQ'(1) << gnt_id_o;
            end
         end
         DONE: begin
            rr_ptr_d = (gnt_id_o == IDW'(NREQ - 1)) ? '0 : gnt_id_o + IDW'(1);
         end
         default: ;
      endcase
   end

   // Datapath and output registers; reset clears everything, aborting a job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_a   <= '0;
         pair_b   <= '0;
         rem      <= '0;
         rr_ptr   <= '0;
         gnt_id_o <= '0;
         a_o      <= '0;
         b_o      <= '0;
         ack_o    <= '0;
         done_o   <= 1'b0;
         busy_o   <= 1'b0;
      end else begin
         pair_a   <= pair_a_d;
         pair_b   <= pair_b_d;
         rem      <= rem_d;
         rr_ptr   <= rr_ptr_d;
         gnt_id_o <= gnt_d;
         a_o      <= a_d;
         b_o      <= b_d;
         ack_o    <= ack_d;
         done_o   <= done_d;
         busy_o   <= busy_d;
      end
   end

endmodule

// File: tb/tb_swap_sched.sv
// tb_swap_sched: directed stimulus for swap_sched with a job-level reference
// model compared against the outputs every cycle.
module tb_swap_sched;

   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam int CW   = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_i;
   logic [NREQ*W-1:0] a_i;
   logic [NREQ*W-1:0] b_i;
   logic [NREQ*CW-1:0] cnt_i;
   logic [NREQ-1:0]   ack_o;
   logic              done_o;
   logic [IDW-1:0]    gnt_id_o;
   logic [W-1:0]      a_o;
   logic [W-1:0]      b_o;
   logic              busy_o;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   swap_sched #(.NREQ(NREQ), .W(W), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .a_i(a_i), .b_i(b_i),
      .cnt_i(cnt_i), .ack_o(ack_o), .done_o(done_o), .gnt_id_o(gnt_id_o),
      .a_o(a_o), .b_o(b_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- job-level reference model ----------------
   // A grant at edge number e0 with count c occupies cycles e0..e0+c, finishes
   // in cycle e0+c and leaves one idle cycle, so the next grant edge is e0+c+2.
   // The result is the swapped pair for odd c, the original pair for even c.
   int            m_cyc, m_e0, m_dcyc, m_free, m_ptr, m_id, m_pick;
   bit            m_have;
   logic [W-1:0]  m_ra, m_rb, m_pa, m_pb, m_a, m_b;
   logic [CW-1:0] m_c;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc = 0; m_e0 = -10; m_dcyc = -10; m_free = 0; m_ptr = 0; m_id = 0;
         m_have = 0; m_ra = '0; m_rb = '0; m_pa = '0; m_pb = '0;
      end else begin
         m_cyc++;
         if (m_cyc >= m_free && req_i != '0) begin
            m_pick = -1;
            for (int i = 0; i < NREQ; i++)
               if (m_pick < 0 && req_i[(m_ptr + i) % NREQ]) m_pick = (m_ptr + i) % NREQ;
            m_c = cnt_i[m_pick*CW +: CW];
            m_a = a_i[m_pick*W +: W];
            m_b = b_i[m_pick*W +: W];
            if (m_have) begin m_pa = m_ra; m_pb = m_rb; end
            m_ra   = m_c[0] ? m_b : m_a;
            m_rb   = m_c[0] ? m_a : m_b;
            m_id   = m_pick;
            m_e0   = m_cyc;
            m_dcyc = m_cyc + int'(m_c);
            m_free = m_cyc + int'(m_c) + 2;
            m_ptr  = (m_pick + 1) % NREQ;
            m_have = 1;
         end
      end
   end

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         logic            e_busy, e_done;
         logic [NREQ-1:0] e_ack;
         e_busy = m_have && m_cyc >= m_e0 && m_cyc <= m_dcyc;
         e_done = m_have && m_cyc == m_dcyc;
         e_ack  = e_done ? (NREQ'(1) << m_id) : '0;
         chk("mdl_busy", 32'(busy_o), 32'(e_busy));
         chk("mdl_done", 32'(done_o), 32'(e_done));
         chk("mdl_ack", 32'(ack_o), 32'(e_ack));
         chk("mdl_gnt", 32'(gnt_id_o), m_have ? m_id : 0);
         chk("mdl_a", 32'(a_o), 32'((m_have && m_cyc >= m_dcyc) ? m_ra : m_pa));
         chk("mdl_b", 32'(b_o), 32'((m_have && m_cyc >= m_dcyc) ? m_rb : m_pb));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_done(output int lat, output int nbusy, output bit got,
                            input int k, input bit scramble);
      lat = 0; nbusy = 0; got = 0;
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         if (busy_o) nbusy++;
         if (done_o) got = 1;
         else if (scramble) begin
            a_i[k*W +: W] = 8'($urandom);
            b_i[k*W +: W] = 8'($urandom);
         end
      end
   endtask

   task automatic run_job(input string tag, input int k, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] c,
                          input logic [7:0] ea, input logic [7:0] eb,
                          input int elat, input bit scramble);
      int lat, nbusy;
      bit got;
      @(negedge clk);
      a_i[k*W +: W]   = a;
      b_i[k*W +: W]   = b;
      cnt_i[k*CW +: CW] = c;
      req_i[k]        = 1'b1;
      wait_done(lat, nbusy, got, k, scramble);
      chk({tag, "_timeout"}, 32'(got), 1);
      chk({tag, "_latency"}, lat, elat);
      chk({tag, "_busy_cycles"}, nbusy, elat);
      chk({tag, "_a"}, 32'(a_o), 32'(ea));
      chk({tag, "_b"}, 32'(b_o), 32'(eb));
      chk({tag, "_gnt"}, 32'(gnt_id_o), k);
      chk({tag, "_ack"}, 32'(ack_o), 32'(NREQ'(1) << k));
      req_i[k] = 1'b0;
      @(negedge clk);
      chk({tag, "_ack_len"}, 32'(ack_o), 0);
      chk({tag, "_done_len"}, 32'(done_o), 0);
      chk({tag, "_idle"}, 32'(busy_o), 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int          lat, nbusy;
      bit          got;
      int          rr_ord [5] = '{0, 1, 2, 3, 0};
      logic [3:0]  rr_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      rst_n = 1'b0; req_i = '0; a_i = '0; b_i = '0; cnt_i = '0;
      #1;
      chk("rst_ack", 32'(ack_o), 0);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_ab", 32'({a_o, b_o}), 0);
      chk("rst_gnt", 32'(gnt_id_o), 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      cmp_en = 1'b1;

      // Odd count: swapped, 4 busy cycles.
      run_job("t1", 0, 8'hA5, 8'h3C, 4'd3, 8'h3C, 8'hA5, 4, 1'b0);
      // Even count and zero count.
      run_job("t2e", 1, 8'h11, 8'h22, 4'd4, 8'h11, 8'h22, 5, 1'b0);
      run_job("t2z", 2, 8'h77, 8'h88, 4'd0, 8'h77, 8'h88, 1, 1'b0);

      // Round-robin with all four requesting, count 1 each.
      req_i = '0;
      pulse_reset();
      @(negedge clk);
      a_i   = {8'h41, 8'h31, 8'h21, 8'h11};
      b_i   = {8'h42, 8'h32, 8'h22, 8'h12};
      cnt_i = {4'd1, 4'd1, 4'd1, 4'd1};
      req_i = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_done(lat, nbusy, got, 0, 1'b0);
         chk("rr_timeout", 32'(got), 1);
         chk("rr_ack", 32'(ack_o), 32'(rr_ack[i]));
         chk("rr_gnt", 32'(gnt_id_o), rr_ord[i]);
         if (i > 0) chk("rr_spacing", 1 + lat, 3);
         req_i[rr_ord[i]] = 1'b0;
         if (i < 4) begin
            @(negedge clk);
            req_i[rr_ord[i]] = 1'b1;
         end
      end
      req_i = '0;
      chk("rr_a_last", 32'(a_o), 32'h12);
      chk("rr_b_last", 32'(b_o), 32'h11);

      // Operands changing during SWAP must not affect the result.
      run_job("t4", 0, 8'hC3, 8'h5A, 4'd5, 8'h5A, 8'hC3, 6, 1'b1);

      // Asynchronous reset in the middle of a cnt=6 job.
      @(negedge clk);
      a_i[7:0] = 8'hAA; b_i[7:0] = 8'h55; cnt_i[3:0] = 4'd6;
      req_i[0] = 1'b1;
      @(negedge clk);
      a_i[31:24] = 8'h12; b_i[31:24] = 8'h34; cnt_i[15:12] = 4'd2;
      req_i[3] = 1'b1;
      repeat (2) @(negedge clk);
      chk("t5_busy_before", 32'(busy_o), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", 32'(busy_o), 0);
      chk("t5_rst_ab", 32'({a_o, b_o}), 0);
      chk("t5_rst_gnt", 32'(gnt_id_o), 0);
      req_i[0] = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("t5_no_ack", 32'({ack_o, done_o}), 0);
      end
      #2 rst_n = 1'b1;
      wait_done(lat, nbusy, got, 3, 1'b0);
      chk("t5_timeout", 32'(got), 1);
      chk("t5_gnt", 32'(gnt_id_o), 3);
      chk("t5_ack", 32'(ack_o), 32'h8);
      chk("t5_ab", 32'({a_o, b_o}), 32'h1234);
      req_i[3] = 1'b0;
      @(negedge clk);

      // Maximum count.
      run_job("t6", 0, 8'h01, 8'h02, 4'hF, 8'h02, 8'h01, 16, 1'b0);
      @(negedge clk);
      chk("t6_stay_idle", 32'(busy_o), 0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
